// File: rtl/thermo_pkg.sv
// Shared thermostat front-panel definitions: clock rate, debounce timing defaults and
// the debouncer state encoding.
package thermo_pkg;

    localparam int unsigned CLK_FREQ_HZ = 100_000_000;

    // Cycle count for a duration in milliseconds at the default clock rate.
    function automatic int unsigned cycles_for_ms(input int unsigned ms);
        return (CLK_FREQ_HZ / 1000) * ms;
    endfunction

    localparam int unsigned DEF_DEBOUNCE_CYCLES = cycles_for_ms(10);
    localparam int unsigned DEF_LONG_CYCLES     = cycles_for_ms(2000);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } db_state_e;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for asynchronous front-panel inputs, synchronous active-low reset.
module sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button into a clean level with one-cycle rise/fall pulses.
// Define DB_LONG_PRESS_EN to add a one-shot long-press pulse on C_LONG.
module button_debouncer
    import thermo_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned LONG_W          = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic BTN_RAW,
    output logic C_DB,
    output logic C_RISE,
    output logic C_FALL,
    output logic C_LONG
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if ((64'd1 << LONG_W) <= 64'(LONG_CYCLES)) begin : g_bad_long_w
        $error("LONG_W too narrow for LONG_CYCLES");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_s;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (BTN_RAW),
        .q_o (btn_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // cnt counts consecutive samples at the new level; a single opposing sample restarts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LOW: begin
                if (btn_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_HIGH;
                        db_d    = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = WAIT_HIGH;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT_HIGH: begin
                if (!btn_s) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    db_d    = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HIGH: begin
                if (!btn_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_LOW;
                        db_d    = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = WAIT_LOW;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT_LOW: begin
                if (btn_s) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    db_d    = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign C_DB   = db_q;
    assign C_RISE = rise_q;
    assign C_FALL = fall_q;

`ifdef DB_LONG_PRESS_EN
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    // Parking one past LONG_LAST marks the pulse as already sent for this press.
    localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] long_q, long_d;
    logic              long_pulse_q, long_pulse_d;

    always_comb begin
        long_d       = long_q;
        long_pulse_d = 1'b0;
        if (state_q == STABLE_HIGH || state_q == WAIT_LOW) begin
            if (long_q == LONG_LAST) begin
                long_d       = LONG_SAT;
                long_pulse_d = 1'b1;
            end else if (long_q < LONG_LAST) begin
                long_d = long_q + LONG_W'(1);
            end
        end
        if (rise_d || fall_d) begin
            long_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            long_q       <= '0;
            long_pulse_q <= 1'b0;
        end else begin
            long_q       <= long_d;
            long_pulse_q <= long_pulse_d;
        end
    end

    assign C_LONG = long_pulse_q;
`else
    assign C_LONG = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: per-cycle run-length model plus directed checks.
module tb_button_debouncer;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 10;

    logic clk = 1'b0;
    logic rst;
    logic BTN_RAW;
    logic C_DB, C_RISE, C_FALL, C_LONG;

    int n_checks = 0;
    int n_errors = 0;
    int rise_seen = 0;
    int fall_seen = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3),
        .LONG_CYCLES     (LONG),
        .LONG_W          (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .BTN_RAW (BTN_RAW),
        .C_DB    (C_DB),
        .C_RISE  (C_RISE),
        .C_FALL  (C_FALL),
        .C_LONG  (C_LONG)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the level accepted is the one held for DEB consecutive samples, where the
    // sample seen at edge n is BTN_RAW as it was at edge n-SYNC.
    bit rawq[$];
    bit m_db, m_rise, m_fall, m_long, s;
    int m_run, m_hi;

    always @(negedge clk) begin
        if (!rst) begin
            rawq.delete();
            for (int i = 0; i < SYNC; i++) rawq.push_back(1'b0);
            m_db = 0; m_rise = 0; m_fall = 0; m_long = 0; m_run = 0; m_hi = 0;
        end else begin
            s = rawq.pop_front();
            rawq.push_back(BTN_RAW);
            m_rise = 0; m_fall = 0; m_long = 0;
`ifdef DB_LONG_PRESS_EN
            if (m_db && m_hi < LONG) begin
                m_hi++;
                if (m_hi == LONG) m_long = 1;
            end
`endif
            if (s != m_db) begin
                m_run++;
                if (m_run == DEB) begin
                    m_db = s; m_rise = s; m_fall = !s; m_run = 0; m_hi = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        check("c_db", C_DB, m_db);
        check("c_rise", C_RISE, m_rise);
        check("c_fall", C_FALL, m_fall);
        check("c_long", C_LONG, m_long);
        if (C_RISE === 1'b1) rise_seen++;
        if (C_FALL === 1'b1) fall_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int r0, f0;

    initial begin
        rst = 1'b0;
        BTN_RAW = 1'b0;
        tick(3);
        check("reset_db", C_DB, 0);
        check("reset_pulses", {C_RISE, C_FALL, C_LONG}, 0);
        rst = 1'b1;
        tick(5);

        // Clean press: edges 1..5 keep C_DB low, edge 6 raises it with one C_RISE.
        BTN_RAW = 1'b1;
        tick(5);
        check("press_db_e5", C_DB, 0);
        tick(1);
        check("press_db_e6", C_DB, 1);
        check("press_rise_e6", C_RISE, 1);
        tick(1);
        check("press_rise_e7", C_RISE, 0);

        // Long press: C_RISE was edge 6, so C_LONG belongs on edge 16 only.
        tick(8);
`ifdef DB_LONG_PRESS_EN
        check("long_e15", C_LONG, 0);
        tick(1);
        check("long_e16", C_LONG, 1);
        tick(1);
        check("long_e17", C_LONG, 0);
`else
        check("long_off_e15", C_LONG, 0);
        tick(1);
        check("long_off_e16", C_LONG, 0);
        tick(1);
`endif
        tick(25);
        check("held_db", C_DB, 1);

        // Release: mirror of the press.
        BTN_RAW = 1'b0;
        f0 = fall_seen;
        tick(5);
        check("rel_db_e5", C_DB, 1);
        tick(1);
        check("rel_db_e6", C_DB, 0);
        check("rel_fall_e6", C_FALL, 1);
        tick(10);
        check("rel_fall_count", fall_seen - f0, 1);

        // Glitch: three high samples fall one short of acceptance.
        r0 = rise_seen; f0 = fall_seen;
        BTN_RAW = 1'b1;
        tick(3);
        BTN_RAW = 1'b0;
        tick(12);
        check("glitch_db", C_DB, 0);
        check("glitch_pulses", (rise_seen - r0) + (fall_seen - f0), 0);

        // Late bounce: the low sample lands when the count is at DEB-1; full restart.
        BTN_RAW = 1'b1;
        tick(3);
        BTN_RAW = 1'b0;
        tick(1);
        BTN_RAW = 1'b1;
        tick(5);
        check("bounce_db_e5", C_DB, 0);
        tick(1);
        check("bounce_db_e6", C_DB, 1);
        check("bounce_rise_e6", C_RISE, 1);
        BTN_RAW = 1'b0;
        tick(10);
        check("bounce_release_db", C_DB, 0);

        // Reset at edge 4 of a press aborts it; C_DB rises 6 edges after release.
        r0 = rise_seen;
        BTN_RAW = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_mid_db", C_DB, 0);
        check("rst_mid_pulses", {C_RISE, C_FALL, C_LONG}, 0);
        check("rst_mid_state", dut.state_q, 0);
        rst = 1'b1;
        tick(5);
        check("rst_after_db_e5", C_DB, 0);
        check("rst_after_rise_count", rise_seen - r0, 0);
        tick(1);
        check("rst_after_db_e6", C_DB, 1);
        check("rst_after_rise_e6", C_RISE, 1);

        // Constant input: no activity.
        r0 = rise_seen; f0 = fall_seen;
        tick(40);
        check("static_pulses", (rise_seen - r0) + (fall_seen - f0), 0);
        check("static_db", C_DB, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
